fft_out_reorder: RTL and testbench

// Output reorder stage directly downstream of fft_top; consumes its out_push_F/out_real_F/out_imag_F stream.
// fft_top emits each N-point frame in bit-reversed bin order; this block buffers whole frames
// and re-emits them in natural bin order (0..N-1).

---
 rtl/fft_out_reorder.sv | 114 +++++++++++
 tb/tb_fft_out_reorder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_reorder.sv
// Ping-pong frame buffer turning fft_top's bit-reversed bin order into natural order (0..N-1).
// One frame is written while the other is read; bin 0 appears one cycle after a frame completes.
module fft_out_reorder #(
  parameter int N      = 16,
  parameter int LOGN   = 4,
  parameter int W      = 16,
  parameter bit BITREV = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_push,
  input  logic signed [W-1:0] in_real,
  input  logic signed [W-1:0] in_imag,
  output logic                in_stall,
  output logic                out_push,
  output logic signed [W-1:0] out_real,
  output logic signed [W-1:0] out_imag,
  input  logic                out_stall
);

  typedef enum logic {EMPTY, STREAM} rd_state_e;

  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int b = 0; b < LOGN; b++) r[b] = a[LOGN-1-b];
    return r;
  endfunction

  logic [2*W-1:0]  mem_q [2*N];
  logic [LOGN-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]      full_q, full_d;
  rd_state_e       state_q, state_d;
  logic [W-1:0]    out_real_q, out_real_d, out_imag_q, out_imag_d;
  logic            accept, load_en;
  logic [LOGN-1:0] wr_addr;

  assign in_stall = full_q[wr_bank_q];
  assign accept   = in_push & ~in_stall;
  assign wr_addr  = BITREV ? bitrev(wr_cnt_q) : wr_cnt_q;
  // The output register may reload whenever it is empty or its current sample is being taken.
  assign load_en  = (state_q == EMPTY) | ~out_stall;

  assign out_push = (state_q == STREAM);
  assign out_real = out_real_q;
  assign out_imag = out_imag_q;

  always_ff @(posedge clk) begin
    if (accept) mem_q[{wr_bank_q, wr_addr}] <= {in_real, in_imag};
  end

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    full_d     = full_q;
    state_d    = state_q;
    out_real_d = out_real_q;
    out_imag_d = out_imag_q;

    if (accept) begin
      if (wr_cnt_q == LAST) begin
        wr_cnt_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    if (load_en) begin
      if (full_q[rd_bank_q]) begin
        state_d                  = STREAM;
        {out_real_d, out_imag_d} = mem_q[{rd_bank_q, rd_cnt_q}];
        if (rd_cnt_q == LAST) begin
          // Bank is released as its last bin is loaded, so the writer can refill it next cycle.
          rd_cnt_d          = '0;
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= 2'b00;
      state_q    <= EMPTY;
      out_real_q <= '0;
      out_imag_q <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      state_q    <= state_d;
      out_real_q <= out_real_d;
      out_imag_q <= out_imag_d;
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: a reordering (BITREV=1) and a plain (BITREV=0) instance share stimulus;
// a frame-level model fills expected queues that a monitor drains on every output transfer.
module tb_fft_out_reorder;
  localparam int N = 16;
  localparam int LOGN = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_push = 1'b0;
  logic [W-1:0] in_real = '0, in_imag = '0;
  logic out_stall = 1'b0;
  logic in_stall1, out_push1, in_stall0, out_push0;
  logic [W-1:0] out_real1, out_imag1, out_real0, out_imag0;

  int total = 0;
  int bad = 0;
  int xfer = 0;
  logic [2*W-1:0] fr[$];
  logic [2*W-1:0] q1[$];
  logic [2*W-1:0] q0[$];
  logic hold = 1'b0;
  logic [4*W-1:0] hold_dat;

  always #5 clk = ~clk;

  fft_out_reorder #(.N(N), .LOGN(LOGN), .W(W), .BITREV(1'b1)) u_rev (
    .clk(clk), .reset(rst_n), .in_push(in_push), .in_real(in_real), .in_imag(in_imag),
    .in_stall(in_stall1), .out_push(out_push1), .out_real(out_real1), .out_imag(out_imag1),
    .out_stall(out_stall));

  fft_out_reorder #(.N(N), .LOGN(LOGN), .W(W), .BITREV(1'b0)) u_nat (
    .clk(clk), .reset(rst_n), .in_push(in_push), .in_real(in_real), .in_imag(in_imag),
    .in_stall(in_stall0), .out_push(out_push0), .out_real(out_real0), .out_imag(out_imag0),
    .out_stall(out_stall));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rev(input int k);
    int r = 0;
    for (int b = 0; b < LOGN; b++) if (k & (1 << b)) r |= 1 << (LOGN - 1 - b);
    return r;
  endfunction

  // Reference model: collect accepted samples; a completed frame yields its expected output order.
  always @(negedge clk) begin
    if (!rst_n) fr.delete();
    else if (in_push && !in_stall1) begin
      fr.push_back({in_real, in_imag});
      if (fr.size() == N) begin
        for (int k = 0; k < N; k++) begin
          q1.push_back(fr[rev(k)]);
          q0.push_back(fr[k]);
        end
        fr.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) hold = 1'b0;
    else begin
      if (hold) begin
        chk("hold_push", {62'd0, out_push1, out_push0}, 64'd3);
        chk("hold_data", {out_real1, out_imag1, out_real0, out_imag0}, hold_dat);
      end
      if (out_push1 && !out_stall) begin
        xfer++;
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got %0h expected none", {out_real1, out_imag1});
        end else chk("bin_rev", {32'd0, out_real1, out_imag1}, {32'd0, q1.pop_front()});
      end
      if (out_push0 && !out_stall) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out_nat: got %0h expected none", {out_real0, out_imag0});
        end else chk("bin_nat", {32'd0, out_real0, out_imag0}, {32'd0, q0.pop_front()});
      end
      hold = out_push1 && out_stall;
      hold_dat = {out_real1, out_imag1, out_real0, out_imag0};
    end
  end

  task automatic push_sample(input logic [W-1:0] r, input logic [W-1:0] i);
    logic acc = 1'b0;
    in_push = 1'b1; in_real = r; in_imag = i;
    for (int c = 0; c < 300 && !acc; c++) begin
      @(negedge clk) acc = !in_stall1;
      @(posedge clk) #1;
    end
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic push_frame_rand();
    for (int k = 0; k < N; k++) push_sample(W'($urandom), W'($urandom));
  endtask

  task automatic drain();
    int c = 0;
    while (c < 400 && (q1.size() != 0 || q0.size() != 0)) begin
      @(posedge clk) #1;
      c++;
    end
    chk("drain_left", 64'(q1.size() + q0.size()), 64'd0);
    repeat (2) @(posedge clk) #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int xf0, acc_n, gaps;
    repeat (3) @(posedge clk) #1;
    chk("rst_out_push", {62'd0, out_push1, out_push0}, 64'd0);
    chk("rst_out_data", {out_real1, out_imag1, out_real0, out_imag0}, 64'd0);
    chk("rst_in_stall", {62'd0, in_stall1, in_stall0}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk) #1;

    // 1: ramp frame, exact latency
    for (int i = 0; i < N; i++) push_sample(W'(i), W'(-i));
    in_push = 1'b0;
    @(negedge clk) chk("lat_early", {62'd0, out_push1, out_push0}, 64'd0);
    @(negedge clk) chk("lat_bin0", {62'd0, out_push1, out_push0}, 64'd3);
    chk("bin0_real", {32'd0, out_real1, out_real0}, 64'd0);
    drain();

    // 2: three back-to-back frames, continuous output and no input stall
    gaps = 0;
    xf0 = xfer;
    fork
      begin
        for (int f = 0; f < 3; f++) push_frame_rand();
        in_push = 1'b0;
      end
      begin
        int c = 0;
        while (c < 300 && !out_push1) begin @(negedge clk); c++; end
        for (int k = 0; k < 3 * N; k++) begin
          if (!out_push1 || in_stall1 || in_stall0) gaps++;
          @(negedge clk);
        end
      end
    join
    drain();
    chk("stream_gaps", 64'(gaps), 64'd0);
    chk("stream_xfers", 64'(xfer - xf0), 64'd48);

    // 3: output stalled 40 cycles while pushing continuously
    out_stall = 1'b1;
    acc_n = 0;
    gaps = 0;
    for (int c = 0; c < 40; c++) begin
      in_push = 1'b1; in_real = W'(acc_n); in_imag = W'($urandom);
      @(negedge clk);
      if (in_stall1 != (acc_n >= 2 * N)) gaps++;
      if (!in_stall1) acc_n++;
      @(posedge clk) #1;
    end
    in_push = 1'b0;
    chk("stall_accepted", 64'(acc_n), 64'd32);
    chk("stall_flag_seq", 64'(gaps), 64'd0);
    chk("stall_out_real", {31'd0, out_push1, out_real1, out_real0}, {31'd0, 1'b1, 32'd0});
    xf0 = xfer;
    out_stall = 1'b0;
    drain();
    chk("stall_release_xfers", 64'(xfer - xf0), 64'd32);

    // 4: out_stall toggling every cycle across two frames
    xf0 = xfer;
    fork
      begin
        for (int f = 0; f < 2; f++) push_frame_rand();
        in_push = 1'b0;
      end
      begin
        for (int c = 0; c < 140; c++) begin
          out_stall = ~out_stall;
          @(posedge clk) #1;
        end
        out_stall = 1'b0;
      end
    join
    drain();
    chk("toggle_xfers", 64'(xfer - xf0), 64'd32);

    // 5: reset with a held output frame and 7 samples of a partial frame
    out_stall = 1'b1;
    push_frame_rand();
    for (int k = 0; k < 7; k++) push_sample(W'($urandom), W'($urandom));
    in_push = 1'b0;
    @(negedge clk) chk("pre_rst_push", {62'd0, out_push1, out_push0}, 64'd3);
    @(posedge clk) #1;
    rst_n = 1'b0;
    q1.delete(); q0.delete();
    #1;
    chk("rst_push_imm", {62'd0, out_push1, out_push0}, 64'd0);
    chk("rst_stall_imm", {62'd0, in_stall1, in_stall0}, 64'd0);
    chk("rst_real_imm", {32'd0, out_real1, out_real0}, 64'd0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    out_stall = 1'b0;
    xf0 = xfer;
    push_frame_rand();
    in_push = 1'b0;
    drain();
    chk("post_rst_xfers", 64'(xfer - xf0), 64'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
